// File: rtl/seg_display_if.sv
// Handshake and result bundle between a value producer and the 7-segment sequencer.
interface seg_display_if #(
  parameter int BIN_W = 14
);
  logic [BIN_W-1:0] bin_in;
  logic             bin_valid;
  logic             bin_ready;
  logic             busy;
  logic [15:0]      bcd_digits;
  logic [3:0]       blank_mask;
  logic             ovf;

  modport master (
    output bin_in, bin_valid,
    input  bin_ready, busy, bcd_digits, blank_mask, ovf
  );

  modport slave (
    input  bin_in, bin_valid,
    output bin_ready, busy, bcd_digits, blank_mask, ovf
  );
endinterface

// File: rtl/seg_display_ctrl.sv
// Binary-to-BCD sequencer for the 4-digit display: serial double-dabble, one bit per clock,
// results published atomically together with the leading-zero blank mask and overflow flag.
//
// state   | meaning
// S_IDLE  | waiting for bin_valid; bin_ready high
// S_SHIFT | add-3 / shift, one input bit per cycle, BIN_W cycles
// S_DONE  | publish digits, blank mask and ovf, return to idle
module seg_display_ctrl #(
  parameter int BIN_W    = 14,
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  seg_display_if.slave bus
);
  localparam int               CNT_W     = $clog2(BIN_W + 1);
  localparam logic [BIN_W-1:0] SAT_VAL   = BIN_W'(9999);
  localparam logic [3:0]       BLANK_RST = LZ_BLANK ? 4'b1110 : 4'b0000;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [BIN_W-1:0] r_bin;
  logic [15:0]      r_bcd;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sat;
  logic [15:0]      r_digits;
  logic [3:0]       r_blank;
  logic             r_ovf;

  logic             w_accept;
  logic             w_sat;
  logic [BIN_W-1:0] w_bin_cap;
  logic             w_last;
  logic [15:0]      w_adj;
  logic [3:0]       w_blank;

  assign w_accept  = (r_state == S_IDLE) && bus.bin_valid;
  assign w_sat     = 32'(bus.bin_in) > 32'd9999;
  assign w_bin_cap = w_sat ? SAT_VAL : bus.bin_in;
  assign w_last    = (r_cnt == CNT_W'(BIN_W - 1));

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < 4; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  // Units digit is never blanked so a zero value still shows "0".
  always_comb begin
    w_blank = 4'b0000;
    if (LZ_BLANK) begin
      w_blank[3] = (r_bcd[15:12] == 4'd0);
      w_blank[2] = w_blank[3] && (r_bcd[11:8] == 4'd0);
      w_blank[1] = w_blank[2] && (r_bcd[7:4] == 4'd0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_last)   w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bin    <= '0;
      r_bcd    <= '0;
      r_cnt    <= '0;
      r_sat    <= 1'b0;
      r_digits <= '0;
      r_blank  <= BLANK_RST;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_bin <= w_bin_cap;
          r_sat <= w_sat;
          r_bcd <= '0;
          r_cnt <= '0;
        end
        S_SHIFT: begin
          r_bcd <= {w_adj[14:0], r_bin[BIN_W-1]};
          r_bin <= {r_bin[BIN_W-2:0], 1'b0};
          r_cnt <= r_cnt + 1'b1;
        end
        S_DONE: begin
          r_digits <= r_bcd;
          r_blank  <= w_blank;
          r_ovf    <= r_sat;
        end
        default: ;
      endcase
    end
  end

  assign bus.bin_ready  = (r_state == S_IDLE);
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.bcd_digits = r_digits;
  assign bus.blank_mask = r_blank;
  assign bus.ovf        = r_ovf;
endmodule

// File: tb/tb_seg_display_ctrl.sv
// Drives two sequencers (blanking on and off) with identical stimulus and compares both
// against a decimal-arithmetic model of the published display value.
module tb_seg_display_ctrl;
  localparam int BIN_W = 14;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seg_display_if #(.BIN_W(BIN_W)) if_lz1 ();
  seg_display_if #(.BIN_W(BIN_W)) if_lz0 ();

  seg_display_ctrl #(.BIN_W(BIN_W), .LZ_BLANK(1'b1)) u_dut_lz1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if_lz1.slave)
  );

  seg_display_ctrl #(.BIN_W(BIN_W), .LZ_BLANK(1'b0)) u_dut_lz0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if_lz0.slave)
  );

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [20:0] exp_lz1;
  logic [20:0] exp_lz0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // {bcd_digits, blank_mask, ovf} the display should show for input x
  function automatic logic [20:0] model(input int x, input bit lz);
    int          v;
    int          d[4];
    logic [15:0] bcd;
    logic [3:0]  bl;
    v = (x > 9999) ? 9999 : x;
    for (int i = 0; i < 4; i++) begin
      d[i] = v % 10;
      v    = v / 10;
      bcd[4*i +: 4] = 4'(d[i]);
    end
    bl = 4'b0000;
    if (lz) begin
      bl[3] = (d[3] == 0);
      bl[2] = bl[3] && (d[2] == 0);
      bl[1] = bl[2] && (d[1] == 0);
    end
    return {bcd, bl, (x > 9999)};
  endfunction

  function automatic logic [20:0] obs_lz1();
    return {if_lz1.bcd_digits, if_lz1.blank_mask, if_lz1.ovf};
  endfunction

  function automatic logic [20:0] obs_lz0();
    return {if_lz0.bcd_digits, if_lz0.blank_mask, if_lz0.ovf};
  endfunction

  task automatic drive(input logic valid, input int v);
    if_lz1.bin_valid = valid;
    if_lz0.bin_valid = valid;
    if_lz1.bin_in    = BIN_W'(v);
    if_lz0.bin_in    = BIN_W'(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for bin_ready after an accept, checking that outputs hold meanwhile.
  task automatic wait_result(input int v, input bit inject, input int inj_v, input bit hold_valid);
    int n;
    n = 0;
    while (!if_lz1.bin_ready && n < 40) begin
      chk_eq("hold_lz1", obs_lz1(), exp_lz1);
      chk_eq("hold_lz0", obs_lz0(), exp_lz0);
      if (inject && n == 3) drive(1'b1, inj_v);
      if (inject && n == 4) drive(1'b0, $urandom_range(0, 16383));
      step();
      n++;
    end
    exp_lz1 = model(v, 1'b1);
    exp_lz0 = model(v, 1'b0);
    chk_eq("latency", n, BIN_W + 1);
    chk_eq("result_lz1", obs_lz1(), exp_lz1);
    chk_eq("result_lz0", obs_lz0(), exp_lz0);
    chk_eq("ready_lz0", if_lz0.bin_ready, 1'b1);
    chk_eq("busy_done", if_lz1.busy, 1'b0);
    if (!hold_valid) chk_eq("valid_low", if_lz1.bin_valid, 1'b0);
  endtask

  task automatic convert(input int v, input bit inject, input int inj_v);
    drive(1'b1, v);
    step();
    drive(1'b0, $urandom_range(0, 16383));
    chk_eq("accept_ready", if_lz1.bin_ready, 1'b0);
    chk_eq("accept_busy", if_lz1.busy, 1'b1);
    wait_result(v, inject, inj_v, 1'b0);
  endtask

  initial begin
    int vals[$];
    reset = 1'b1;
    drive(1'b0, 0);
    repeat (3) step();
    exp_lz1 = model(0, 1'b1);
    exp_lz0 = model(0, 1'b0);
    chk_eq("rst_lz1", obs_lz1(), exp_lz1);
    chk_eq("rst_lz0", obs_lz0(), exp_lz0);
    chk_eq("rst_ready", if_lz1.bin_ready, 1'b1);
    chk_eq("rst_busy", if_lz1.busy, 1'b0);
    reset = 1'b0;
    step();

    vals = '{1234, 7, 0, 40, 12000, 9999, 10000, 16383, 9, 100, 1000};
    foreach (vals[i]) convert(vals[i], 1'b0, 0);
    for (int i = 0; i < 20; i++) convert(int'($urandom_range(0, 16383)), 1'b0, 0);

    // valid pulse during SHIFT must be ignored
    convert(4321, 1'b1, 5678);
    step();
    chk_eq("no_extra_accept", if_lz1.bin_ready, 1'b1);
    convert(5678, 1'b0, 0);

    // reset mid-conversion aborts without publishing
    drive(1'b1, 5555);
    step();
    drive(1'b0, 0);
    repeat (6) step();
    reset = 1'b1;
    #1;
    exp_lz1 = model(0, 1'b1);
    exp_lz0 = model(0, 1'b0);
    chk_eq("abort_lz1", obs_lz1(), exp_lz1);
    chk_eq("abort_lz0", obs_lz0(), exp_lz0);
    chk_eq("abort_ready", if_lz1.bin_ready, 1'b1);
    chk_eq("abort_busy", if_lz1.busy, 1'b0);
    step();
    reset = 1'b0;
    step();
    chk_eq("post_abort_hold", obs_lz1(), exp_lz1);
    convert(42, 1'b0, 0);

    // back-to-back with valid held high
    drive(1'b1, 1);
    for (int v = 1; v <= 100; v++) begin
      step();
      chk_eq("b2b_accept", if_lz1.bin_ready, 1'b0);
      if (v < 100) drive(1'b1, v + 1);
      else         drive(1'b0, 0);
      wait_result(v, 1'b0, 0, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
